// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
// Holds a word-addressed synchronous data memory. ALU ops, stores and
// misaligned accesses retire one cycle after acceptance. Loads take two
// cycles and hold off upstream for the extra cycle.
module mem_stage #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] ALUResult,
  input  logic [31:0] storeData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic [4:0]  regDst,
  input  logic        flush,
  output logic        stall_out,
  output logic        out_valid,
  output logic [31:0] wbData,
  output logic [4:0]  wbReg,
  output logic        wbRegWrite,
  output logic        misaligned
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0] mem [DEPTH];

  // Upper address bits above the word index are dropped, so addresses wrap.
  function automatic logic [ADDR_BITS-1:0] word_index(input logic [31:0] addr);
    return addr[ADDR_BITS+1:2];
  endfunction

  // Only memory instructions can be misaligned; ALU results are free-form.
  function automatic logic is_misaligned(input logic [31:0] addr,
                                         input logic        rd,
                                         input logic        wr);
    return (addr[1:0] != 2'b00) && (rd || wr);
  endfunction

  logic                 accept;
  logic                 misal;
  logic                 do_store;
  logic                 do_load;
  logic [ADDR_BITS-1:0] idx;

  // Captured load context, used one cycle later when the word is read.
  logic [ADDR_BITS-1:0] ld_idx_p0;
  logic [4:0]           ld_reg_p0;
  logic                 ld_rw_p0;

  assign accept   = in_valid && (state == IDLE) && !flush;
  assign misal    = is_misaligned(ALUResult, MemRead, MemWrite);
  assign idx      = word_index(ALUResult);
  // A store wins when both memory bits are set.
  assign do_store = accept && MemWrite && !misal;
  assign do_load  = accept && MemRead && !MemWrite && !misal;

  assign stall_out = (state == LOAD_WAIT);

  // Next-state logic: a load parks the stage for one cycle; LOAD_WAIT
  // always returns to IDLE, whether the load completes or is flushed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (do_load) state_nxt = LOAD_WAIT;
      LOAD_WAIT: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_store) mem[idx] <= storeData;
  end

  // ---- stage p0: latch load address and destination at acceptance ----
  always_ff @(posedge clk) begin
    if (do_load) begin
      ld_idx_p0 <= idx;
      ld_reg_p0 <= regDst;
      ld_rw_p0  <= RegWrite;
    end
  end

  // ---- stage p1: registered writeback bundle ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      wbData     <= 32'd0;
      wbReg      <= 5'd0;
      wbRegWrite <= 1'b0;
      misaligned <= 1'b0;
    end else if (state == LOAD_WAIT) begin
      misaligned <= 1'b0;
      if (flush) begin
        out_valid  <= 1'b0;
        wbRegWrite <= 1'b0;
      end else begin
        out_valid  <= 1'b1;
        wbData     <= mem[ld_idx_p0];
        wbReg      <= ld_reg_p0;
        wbRegWrite <= ld_rw_p0;
      end
    end else if (accept && !do_load) begin
      out_valid  <= 1'b1;
      wbData     <= ALUResult;
      wbReg      <= regDst;
      wbRegWrite <= RegWrite && !misal;
      misaligned <= misal;
    end else begin
      out_valid  <= 1'b0;
      wbRegWrite <= 1'b0;
      misaligned <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver updates an array memory model
// and queues expected writeback bundles; a monitor compares on out_valid.
module tb_mem_stage;

  localparam int AB = 10;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] ALUResult;
  logic [31:0] storeData;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic [4:0]  regDst;
  logic        flush;
  logic        stall_out;
  logic        out_valid;
  logic [31:0] wbData;
  logic [4:0]  wbReg;
  logic        wbRegWrite;
  logic        misaligned;

  mem_stage #(.ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ALUResult(ALUResult),
    .storeData(storeData), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .regDst(regDst), .flush(flush),
    .stall_out(stall_out), .out_valid(out_valid), .wbData(wbData),
    .wbReg(wbReg), .wbRegWrite(wbRegWrite), .misaligned(misaligned)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rg;
    logic        rw;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [1 << AB];
  logic        pending_load;
  int          errors;
  int          checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus; the model decides acceptance from its own state.
  task automatic issue(input logic v, input logic [31:0] a, input logic [31:0] sd,
                       input logic mr, input logic mw, input logic rw,
                       input logic [4:0] rd, input logic fl, output logic acc);
    exp_t          e;
    logic [AB-1:0] ix;
    logic          mis;
    in_valid = v; ALUResult = a; storeData = sd; MemRead = mr;
    MemWrite = mw; RegWrite = rw; regDst = rd; flush = fl;
    chk("stall_out", {31'd0, stall_out}, {31'd0, pending_load});
    acc = 1'b0;
    if (pending_load) begin
      if (fl && sb.size() > 0) e = sb.pop_back();
      pending_load = 1'b0;
    end else if (v && !fl) begin
      acc = 1'b1;
      ix  = a[AB+1:2];
      mis = (a[1:0] != 2'b00) && (mr || mw);
      e.data = a; e.rg = rd; e.rw = rw; e.mis = 1'b0;
      if (mis) begin
        e.rw = 1'b0; e.mis = 1'b1;
      end else if (mw) begin
        mem_m[ix] = sd;
      end else if (mr) begin
        e.data = mem_m[ix];
        pending_load = 1'b1;
      end
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] sd, input logic mr,
                      input logic mw, input logic rw, input logic [4:0] rd);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 3 && !acc; i++) issue(1'b1, a, sd, mr, mw, rw, rd, 1'b0, acc);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted t=%0t", $time);
    end
  endtask

  // Monitor: pop and compare on every valid writeback, check invariant otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid actual=1 required=0 t=%0t", $time);
        end else begin
          e = sb.pop_front();
          chk("wbData", wbData, e.data);
          chk("wbReg", {27'd0, wbReg}, {27'd0, e.rg});
          chk("wbRegWrite", {31'd0, wbRegWrite}, {31'd0, e.rw});
          chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
        end
      end else begin
        chk("bubble_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_ctrl", {30'd0, wbRegWrite, misaligned}, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [31:0] a;
    int          kind;
    errors = 0; checks = 0; pending_load = 1'b0;
    reset = 1'b0; in_valid = 1'b0; ALUResult = '0; storeData = '0;
    MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; regDst = '0; flush = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wbData", wbData, 32'd0);
    chk("rst_wbReg", {27'd0, wbReg}, 32'd0);
    chk("rst_wbRegWrite", {31'd0, wbRegWrite}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_stall_out", {31'd0, stall_out}, 32'd0);
    reset = 1'b0;

    // Fill every word so later loads have defined contents.
    for (int i = 0; i < (1 << AB); i++) send(i * 4, $urandom, 1'b0, 1'b1, 1'b0, 5'd0);

    // ALU pass-through.
    send(32'h0000_1234, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5);
    // Store then back-to-back load; the following ALU op is held one cycle.
    send(32'h40, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 5'd1);
    send(32'h40, 32'd0, 1'b1, 1'b0, 1'b1, 5'd8);
    send(32'h777, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3);
    // Misaligned store leaves the word intact.
    send(32'h42, 32'h1, 1'b0, 1'b1, 1'b1, 5'd2);
    send(32'h40, 32'd0, 1'b1, 1'b0, 1'b1, 5'd9);
    // Address wrap.
    send(32'h1000, 32'h55, 1'b0, 1'b1, 1'b0, 5'd0);
    send(32'h0000, 32'd0, 1'b1, 1'b0, 1'b1, 5'd10);
    // Flush in IDLE drops a store.
    issue(1'b1, 32'h80, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, acc);
    send(32'h80, 32'd0, 1'b1, 1'b0, 1'b1, 5'd4);
    // Both MemRead and MemWrite: treated as store.
    send(32'h84, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b1, 5'd6);
    send(32'h84, 32'd0, 1'b1, 1'b0, 1'b1, 5'd7);
    // Flush during LOAD_WAIT.
    send(32'h40, 32'd0, 1'b1, 1'b0, 1'b1, 5'd11);
    issue(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, acc);
    issue(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, acc);

    // Asynchronous reset in the middle of a load.
    send(32'h100, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 5'd0);
    send(32'h100, 32'd0, 1'b1, 1'b0, 1'b1, 5'd12);
    chk("midload_stall", {31'd0, stall_out}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_stall_out", {31'd0, stall_out}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_wbData", wbData, 32'd0);
    chk("arst_misaligned", {31'd0, misaligned}, 32'd0);
    if (sb.size() > 0) void'(sb.pop_back());
    pending_load = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    send(32'h100, 32'd0, 1'b1, 1'b0, 1'b1, 5'd13);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      kind = $urandom_range(0, 3);
      issue($urandom_range(0, 7) != 0, a, $urandom,
            kind == 2 || kind == 3, kind == 1 || kind == 3,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom_range(0, 9) == 0, acc);
    end

    repeat (4) issue(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, acc);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
